// File: rtl/block_check_pkg.sv
// Shared definitions for the block-checker scheduler.
//   state_e   : scheduler FSM states
//   CH_SPACE  : word separator byte seen by the checker engine
//   CH_NUL    : byte driven to the engine when nothing is forwarded
//   MAX_REQ   : largest supported number of requesters
//   IDX_W     : width of a requester index
//   rr_next() : round-robin pointer increment with wrap at n
package block_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam int         MAX_REQ  = 8;
    localparam int         IDX_W    = 3;

    // Next pointer after serving requester idx, wrapping at n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        logic [IDX_W-1:0] nxt;
        if (int'(idx) >= (n - 1)) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/block_check_sched_rr_pick.sv
// Combinational round-robin selector.
//   req       : request vector, one bit per requester
//   ptr       : index with highest priority this round
//   grant_idx : first requesting index at or after ptr (wrapping upward)
//   any       : at least one request is present
module rr_pick
    import block_check_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    assign any = |req;

    // Scan from the farthest offset down so the nearest request at or after ptr wins.
    always_comb begin : p_pick
        int idx;
        grant_idx = {IDX_W{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                grant_idx = idx[IDX_W-1:0];
            end else begin
                grant_idx = grant_idx;
            end
        end
    end

endmodule

// File: rtl/block_check_sched.sv
// Round-robin scheduler sharing one begin/end block-checker engine among
// N_REQ byte-stream requesters. One requester owns the engine per message:
// the engine is cleared, the bytes are forwarded through chk_en/chk_in, and
// the verdict is handed back with a one-cycle done pulse.
//
// Optional feature macro: BLOCK_SCHED_TIMEOUT_EN
//   defined   : a mid-message stall of TIMEOUT cycles aborts with err=1
//   undefined : no stall counter, err tied to 0
//
// Ports
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/data/last  : per-requester byte streams (data byte i at [8i+7:8i])
//   req_ready            : byte accepted when valid & ready
//   done, result, err    : registered verdict pulse to the owner
//   chk_clr, chk_en      : engine clear and byte enable
//   chk_in               : byte to the engine (0x00 when not enabled)
//   chk_result           : engine verdict
module block_check_sched
    import block_check_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     done,
    output logic                 result,
    output logic                 err,
    output logic                 chk_clr,
    output logic                 chk_en,
    output logic [7:0]           chk_in,
    input  logic                 chk_result
);

    localparam int DW = 8 * MAX_REQ;

    if ((N_REQ < 2) || (N_REQ > MAX_REQ) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_param_check
        $error("block_check_sched: N_REQ or TIMEOUT out of range");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               result_q, result_d;

    logic [IDX_W-1:0]   pick_s;
    logic               any_s;
    logic [MAX_REQ-1:0] valid_ext_s;
    logic [MAX_REQ-1:0] last_ext_s;
    logic [DW-1:0]      data_ext_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic [7:0]         g_data_s;
    logic [N_REQ-1:0]   owner_oh_s;

`ifdef BLOCK_SCHED_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0]         stall_q, stall_d;
    logic               err_q, err_d;
`endif

    // Widen the request buses to MAX_REQ so a 3-bit owner index always selects in range.
    assign valid_ext_s = MAX_REQ'(req_valid);
    assign last_ext_s  = MAX_REQ'(req_last);
    assign data_ext_s  = DW'(req_data);
    assign g_valid_s   = valid_ext_s[grant_q];
    assign g_last_s    = last_ext_s[grant_q];
    assign g_data_s    = data_ext_s[{grant_q, 3'b000} +: 8];
    assign owner_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    rr_pick #(
        .N_REQ     (N_REQ)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_idx (pick_s),
        .any       (any_s)
    );

    // State, owner, pointer and verdict registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= {IDX_W{1'b0}};
            ptr_q    <= {IDX_W{1'b0}};
            done_q   <= {N_REQ{1'b0}};
            result_q <= 1'b0;
`ifdef BLOCK_SCHED_TIMEOUT_EN
            stall_q  <= 8'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef BLOCK_SCHED_TIMEOUT_EN
            stall_q  <= stall_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic; the verdict is captured on the edge that enters DONE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        done_d   = {N_REQ{1'b0}};
        result_d = 1'b0;
`ifdef BLOCK_SCHED_TIMEOUT_EN
        stall_d  = stall_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef BLOCK_SCHED_TIMEOUT_EN
                stall_d = 8'd0;
`endif
                if (any_s) begin
                    grant_d = pick_s;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (g_valid_s) begin
`ifdef BLOCK_SCHED_TIMEOUT_EN
                    stall_d = 8'd0;
`endif
                    if (g_last_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
`ifdef BLOCK_SCHED_TIMEOUT_EN
                    // Abort on the stall cycle that would bring the count to TIMEOUT.
                    if ((stall_q + 8'd1) == TIMEOUT_C) begin
                        state_d  = ST_DONE;
                        done_d   = owner_oh_s;
                        err_d    = 1'b1;
                        result_d = 1'b0;
                    end else begin
                        stall_d  = stall_q + 8'd1;
                        state_d  = ST_STREAM;
                    end
`else
                    state_d = ST_STREAM;
`endif
                end
            end
            ST_WAIT: begin
                state_d  = ST_DONE;
                done_d   = owner_oh_s;
                result_d = chk_result;
            end
            ST_DONE: begin
                ptr_d   = rr_next(grant_q, N_REQ);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine-side and ready outputs decoded from the current state.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        chk_clr   = 1'b0;
        chk_en    = 1'b0;
        chk_in    = CH_NUL;
        case (state_q)
            ST_CLEAR: begin
                chk_clr = 1'b1;
            end
            ST_STREAM: begin
                req_ready = owner_oh_s;
                chk_en    = g_valid_s;
                if (g_valid_s) begin
                    chk_in = g_data_s;
                end else begin
                    chk_in = CH_NUL;
                end
            end
            default: begin
                chk_clr = 1'b0;
            end
        endcase
    end

    assign done   = done_q;
    assign result = result_q;
`ifdef BLOCK_SCHED_TIMEOUT_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_block_check_sched.sv
// Self-checking bench for block_check_sched with three requesters, a
// behavioural begin/end engine and a transaction-timeline reference model.
module tb_block_check_sched;

    localparam int NR = 3;
`ifdef BLOCK_SCHED_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     done;
    logic              result;
    logic              err;
    logic              chk_clr;
    logic              chk_en;
    logic [7:0]        chk_in;
    logic              chk_result;

    always #5 clk = ~clk;

    block_check_sched #(.N_REQ(NR), .TIMEOUT(TB_TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .done       (done),
        .result     (result),
        .err        (err),
        .chk_clr    (chk_clr),
        .chk_en     (chk_en),
        .chk_in     (chk_in),
        .chk_result (chk_result)
    );

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Begin/end word matcher: balanced, never closing an unopened block, at least one block.
    function automatic logic match_fn(input logic [511:0] v, input int n_in);
        int          depth = 0;
        int          wl    = 0;
        int          n;
        logic        ok    = 1'b1;
        logic        saw   = 1'b0;
        logic [63:0] w     = 64'd0;
        logic [7:0]  c;
        n = (n_in > 64) ? 64 : n_in;
        for (int i = 0; i <= n; i++) begin
            c = (i < n) ? v[8*i +: 8] : 8'h20;
            if (c == 8'h20) begin
                if (wl == 5 && w == 64'h62_65_67_69_6E) begin
                    depth++;
                    saw = 1'b1;
                end else if (wl == 3 && w == 64'h65_6E_64) begin
                    if (depth == 0) ok = 1'b0;
                    else depth--;
                end
                w  = 64'd0;
                wl = 0;
            end else begin
                w = {w[55:0], c};
                wl++;
            end
        end
        return ok && saw && (depth == 0);
    endfunction

    // Engine: collects forwarded bytes, cleared by chk_clr; verdict visible after the edge.
    logic [511:0] eng_vec = '0;
    int           eng_len = 0;
    always @(posedge clk) begin
        if (chk_clr) begin
            eng_len <= 0;
        end else if (chk_en && eng_len < 64) begin
            eng_vec[8*eng_len +: 8] <= chk_in;
            eng_len <= eng_len + 1;
        end
    end
    assign chk_result = match_fn(eng_vec, eng_len);

    // Sources: entries 0..255 byte, +256 marks last byte, -1 is one idle cycle.
    int src_q[NR][$];

    task automatic push_msg(input int r, input string s, input int stall_pct,
                            input int stall_at, input int stall_len);
        for (int k = 0; k < s.len(); k++) begin
            if (k == stall_at) repeat (stall_len) src_q[r].push_back(-1);
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) src_q[r].push_back(-1);
            src_q[r].push_back(int'(s[k]) + ((k == s.len() - 1) ? 256 : 0));
        end
    endtask

    function automatic string rand_msg();
        string words[4] = '{"begin", "end", "beGin", "x"};
        string s = "";
        int nw = $urandom_range(1, 5);
        for (int w = 0; w < nw; w++) begin
            if (w > 0) s = {s, " "};
            s = {s, words[$urandom_range(3)]};
        end
        return s;
    endfunction

    // Reference model: one message timeline (grant cycle, last-byte cycle) at a time.
    logic         m_busy = 1'b0;
    logic         m_last = 1'b0;
    logic         m_err  = 1'b0;
    int           m_owner = 0;
    int           m_gcyc  = 0;
    int           m_lcyc  = 0;
    int           m_ptr   = 0;
    int           m_len   = 0;
    int           m_stall = 0;
    logic [511:0] m_vec   = '0;

    task automatic model_check();
        logic          streaming, done_now, exp_en, exp_res, found;
        logic [NR-1:0] exp_rdy, exp_done;
        logic [7:0]    d, exp_in;
        streaming = m_busy && !m_last && (cyc >= m_gcyc + 2);
        done_now  = m_busy && m_last && (cyc == m_lcyc + 2);
        exp_rdy   = streaming ? (NR'(1) << m_owner) : '0;
        exp_en    = streaming && req_valid[m_owner];
        d         = req_data[8*m_owner +: 8];
        exp_in    = exp_en ? d : 8'h00;
        exp_done  = done_now ? (NR'(1) << m_owner) : '0;
        exp_res   = done_now && !m_err && match_fn(m_vec, m_len);
        check_val("chk_clr",   32'(chk_clr),   32'(m_busy && cyc == m_gcyc + 1));
        check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_val("chk_en",    32'(chk_en),    32'(exp_en));
        check_val("chk_in",    32'(chk_in),    32'(exp_in));
        check_val("done",      32'(done),      32'(exp_done));
        check_val("result",    32'(result),    32'(exp_res));
        check_val("err",       32'(err),       32'(done_now && m_err));
        if (done_now) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NR;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && req_valid[(m_ptr + k) % NR]) begin
                    m_owner = (m_ptr + k) % NR;
                    found   = 1'b1;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_gcyc = cyc; m_last = 1'b0;
                m_err = 1'b0;  m_len = 0;    m_stall = 0;
            end
        end else if (streaming) begin
            if (req_valid[m_owner]) begin
                if (m_len < 64) m_vec[8*m_len +: 8] = d;
                m_len++;
                m_stall = 0;
                if (req_last[m_owner]) begin
                    m_last = 1'b1;
                    m_lcyc = cyc;
                end
            end else begin
                m_stall++;
`ifdef BLOCK_SCHED_TIMEOUT_EN
                if (m_stall == TB_TO) begin
                    m_last = 1'b1;
                    m_lcyc = cyc - 1;
                    m_err  = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin
            req_data[8*i +: 8] = 8'($urandom_range(255));
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            if (src_q[i].size() > 0 && src_q[i][0] >= 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end
        end
        @(negedge clk);
        model_check();
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && (src_q[i][0] < 0 || acc[i])) void'(src_q[i].pop_front());
        end
    endtask

    function automatic logic pending();
        logic p = m_busy;
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_quiet(input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check_val("run_bound", 32'd1, 32'd0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_val({pfx, "_ready"},  32'(req_ready), 32'd0);
        check_val({pfx, "_done"},   32'(done),      32'd0);
        check_val({pfx, "_result"}, 32'(result),    32'd0);
        check_val({pfx, "_err"},    32'(err),       32'd0);
        check_val({pfx, "_clr"},    32'(chk_clr),   32'd0);
        check_val({pfx, "_en"},     32'(chk_en),    32'd0);
        check_val({pfx, "_in"},     32'(chk_in),    32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full "begin end" message with valid held high.
        push_msg(0, "begin end", 0, -1, 0);
        run_quiet(100);
        // Two simultaneous "end" requests.
        push_msg(0, "end", 0, -1, 0);
        push_msg(1, "end", 0, -1, 0);
        run_quiet(100);
        // Stalled and unstalled "beGin" on requester 1.
        push_msg(1, "beGin", 0, 4, 3);
        run_quiet(100);
        push_msg(1, "beGin", 0, -1, 0);
        run_quiet(100);
        // Single-byte message.
        push_msg(1, " ", 0, -1, 0);
        run_quiet(100);

        // Reset in the middle of a message stream.
        push_msg(0, "begin begin end end", 0, -1, 0);
        repeat (5) step();
        reset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        for (int i = 0; i < NR; i++) src_q[i].delete();
        req_valid = '0;
        m_busy    = 1'b0;
        m_ptr     = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        push_msg(0, "begin end", 0, -1, 0);
        run_quiet(100);

`ifdef BLOCK_SCHED_TIMEOUT_EN
        push_msg(0, "begin", 0, 2, 10);
        run_quiet(200);
`endif

        // Randomized traffic with random stalls across all requesters.
        repeat (40) begin
            push_msg($urandom_range(NR - 1), rand_msg(), 15, -1, 0);
            repeat ($urandom_range(10)) step();
        end
        run_quiet(20000);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
